// File: rtl/flexbex_dmem_pkg.sv
// Shared types and constants for the flexbex data-memory arbiter and its decoder.
package flexbex_dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BANK_IDX_W = 3;

  typedef enum logic {
    CORE = 1'b0,
    FAB  = 1'b1
  } master_e;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic                  is_read;
    logic [BANK_IDX_W-1:0] bank;
  } pend_t;

endpackage

// File: rtl/flexbex_dmem_arbiter_if.sv
// OBI-style request/response port between one bus master and the data-memory arbiter.
interface flexbex_dmem_arbiter_if;

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, err, rdata
  );

endinterface

// File: rtl/flexbex_dmem_decode.sv
// Combinational decode of a byte address into bank index, bank word address and
// an out-of-window flag for the contiguous multi-bank data window.
module flexbex_dmem_decode
  import flexbex_dmem_pkg::*;
#(
  parameter int          NUM_BANKS = 2,
  parameter int          BANK_AW   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]           i_addr,
  output logic [BANK_IDX_W-1:0] o_bank,
  output logic [BANK_AW-1:0]    o_word,
  output logic                  o_oow
);

  localparam int OFF_LSB  = $clog2(WORD_BYTES);
  localparam int BANK_LSB = BANK_AW + OFF_LSB;

  logic [31:0] w_off;
  logic [31:0] w_bank_full;
  logic        w_unused_lsb;

  assign w_off        = i_addr - BASE_ADDR;
  assign w_bank_full  = w_off >> BANK_LSB;
  assign o_word       = w_off[BANK_LSB-1:OFF_LSB];
  assign o_bank       = w_bank_full[BANK_IDX_W-1:0];
  // The full bank number is compared so that wrap-around addresses far above the window are caught.
  assign o_oow        = (i_addr < BASE_ADDR) || (w_bank_full >= 32'(NUM_BANKS));
  assign w_unused_lsb = ^w_off[OFF_LSB-1:0];

endmodule

// File: rtl/flexbex_dmem_arbiter.sv
// Data-memory arbiter: ibex core port plus optional eFPGA fabric port onto NUM_BANKS SRAM banks.
// Fabric port is enabled by defining FLEXBEX_DMEM_FABRIC_PORT_EN; otherwise the core always wins.
module flexbex_dmem_arbiter
  import flexbex_dmem_pkg::*;
#(
  parameter int          NUM_BANKS = 2,
  parameter int          BANK_AW   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  flexbex_dmem_arbiter_if.slave        core,
  flexbex_dmem_arbiter_if.slave        fab,
  output logic [NUM_BANKS-1:0]         bank_csb_o,
  output logic [NUM_BANKS-1:0]         bank_web_o,
  output logic [4*NUM_BANKS-1:0]       bank_wmask_o,
  output logic [BANK_AW*NUM_BANKS-1:0] bank_addr_o,
  output logic [32*NUM_BANKS-1:0]      bank_din_o,
  input  logic [32*NUM_BANKS-1:0]      bank_dout_i
);

  function automatic logic [31:0] pick_dout(input logic [BANK_IDX_W-1:0] idx,
                                            input logic [32*NUM_BANKS-1:0] dout);
    logic [31:0] v;
    v = 32'h0000_0000;
    for (int b = 0; b < NUM_BANKS; b++) begin
      v = v | (dout[b*32 +: 32] & {32{idx == BANK_IDX_W'(b)}});
    end
    return v;
  endfunction

  logic [BANK_IDX_W-1:0] w_core_bank;
  logic [BANK_AW-1:0]    w_core_word;
  logic                  w_core_oow;
  logic                  w_core_gnt;
  logic                  w_core_sel;
  pend_t                 r_core_pend;

  logic [BANK_IDX_W-1:0] w_fab_bank;
  logic [BANK_AW-1:0]    w_fab_word;
  logic                  w_fab_oow;
  logic                  w_fab_gnt;
  logic                  w_fab_sel;

  flexbex_dmem_decode #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_AW   (BANK_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_core_dec (
    .i_addr (core.addr),
    .o_bank (w_core_bank),
    .o_word (w_core_word),
    .o_oow  (w_core_oow)
  );

`ifdef FLEXBEX_DMEM_FABRIC_PORT_EN
  pend_t                 r_fab_pend;
  logic [NUM_BANKS-1:0]  r_last_win;
  logic                  w_contest;
  logic                  w_last_fab;
  master_e               w_winner;

  flexbex_dmem_decode #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_AW   (BANK_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_fab_dec (
    .i_addr (fab.addr),
    .o_bank (w_fab_bank),
    .o_word (w_fab_word),
    .o_oow  (w_fab_oow)
  );

  // Last winner of the contested bank (both masters target the same bank in a contest).
  always_comb begin
    w_last_fab = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_last_fab = w_last_fab | (r_last_win[b] & (w_core_bank == BANK_IDX_W'(b)));
    end
  end

  assign w_contest  = core.req & fab.req & ~w_core_oow & ~w_fab_oow & (w_core_bank == w_fab_bank);
  assign w_winner   = w_last_fab ? CORE : FAB;
  assign w_core_gnt = ~reset & core.req & (~w_contest | (w_winner == CORE));
  assign w_fab_gnt  = ~reset & fab.req  & (~w_contest | (w_winner == FAB));
  assign w_fab_sel  = w_fab_gnt & ~w_fab_oow;

  // Per-bank last-winner registers, flipped only when a contest is resolved on that bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_win <= {NUM_BANKS{1'b1}};
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_contest && (w_core_bank == BANK_IDX_W'(b))) begin
          r_last_win[b] <= w_winner;
        end
      end
    end
  end

  // Fabric pending-response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fab_pend <= '{valid: 1'b0, err: 1'b0, is_read: 1'b0, bank: {BANK_IDX_W{1'b0}}};
    end else begin
      r_fab_pend.valid   <= w_fab_gnt;
      r_fab_pend.err     <= w_fab_gnt & w_fab_oow;
      r_fab_pend.is_read <= w_fab_gnt & ~w_fab_oow & ~fab.we;
      r_fab_pend.bank    <= w_fab_bank;
    end
  end

  assign fab.gnt    = w_fab_gnt;
  assign fab.rvalid = r_fab_pend.valid;
  assign fab.err    = r_fab_pend.valid & r_fab_pend.err;
  assign fab.rdata  = (r_fab_pend.valid & r_fab_pend.is_read) ?
                      pick_dout(r_fab_pend.bank, bank_dout_i) : 32'h0000_0000;
`else
  logic w_unused_fab;

  assign w_core_gnt   = ~reset & core.req;
  assign w_fab_bank   = {BANK_IDX_W{1'b0}};
  assign w_fab_word   = {BANK_AW{1'b0}};
  assign w_fab_oow    = 1'b0;
  assign w_fab_gnt    = 1'b0;
  assign w_fab_sel    = w_fab_gnt & ~w_fab_oow;
  assign w_unused_fab = ^{fab.req, fab.addr};

  assign fab.gnt    = 1'b0;
  assign fab.rvalid = 1'b0;
  assign fab.err    = 1'b0;
  assign fab.rdata  = 32'h0000_0000;
`endif

  assign w_core_sel = w_core_gnt & ~w_core_oow;

  // Core pending-response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_pend <= '{valid: 1'b0, err: 1'b0, is_read: 1'b0, bank: {BANK_IDX_W{1'b0}}};
    end else begin
      r_core_pend.valid   <= w_core_gnt;
      r_core_pend.err     <= w_core_gnt & w_core_oow;
      r_core_pend.is_read <= w_core_gnt & ~w_core_oow & ~core.we;
      r_core_pend.bank    <= w_core_bank;
    end
  end

  assign core.gnt    = w_core_gnt;
  assign core.rvalid = r_core_pend.valid;
  assign core.err    = r_core_pend.valid & r_core_pend.err;
  assign core.rdata  = (r_core_pend.valid & r_core_pend.is_read) ?
                       pick_dout(r_core_pend.bank, bank_dout_i) : 32'h0000_0000;

  // Bank port 0 drive: at most one granted master targets each bank in a cycle.
  always_comb begin
    bank_csb_o   = {NUM_BANKS{1'b1}};
    bank_web_o   = {NUM_BANKS{1'b1}};
    bank_wmask_o = {(4*NUM_BANKS){1'b0}};
    bank_addr_o  = {(BANK_AW*NUM_BANKS){1'b0}};
    bank_din_o   = {(32*NUM_BANKS){1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_core_sel && (w_core_bank == BANK_IDX_W'(b))) begin
        bank_csb_o[b]                   = 1'b0;
        bank_web_o[b]                   = ~core.we;
        bank_wmask_o[b*4 +: 4]          = core.be;
        bank_addr_o[b*BANK_AW +: BANK_AW] = w_core_word;
        bank_din_o[b*32 +: 32]          = core.wdata;
      end else if (w_fab_sel && (w_fab_bank == BANK_IDX_W'(b))) begin
        bank_csb_o[b]                   = 1'b0;
        bank_web_o[b]                   = ~fab.we;
        bank_wmask_o[b*4 +: 4]          = fab.be;
        bank_addr_o[b*BANK_AW +: BANK_AW] = w_fab_word;
        bank_din_o[b*32 +: 32]          = fab.wdata;
      end else begin
        bank_csb_o[b] = 1'b1;
        bank_web_o[b] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flexbex_dmem_arbiter.sv
// Self-checking bench for flexbex_dmem_arbiter: bank emulators, a word-level memory model
// with per-bank contest history, directed literal checks, then randomized traffic.
module tb_flexbex_dmem_arbiter;

  localparam int          NB  = 2;
  localparam int          AW  = 8;
  localparam logic [31:0] WIN = 32'(NB * 1024);
`ifdef FLEXBEX_DMEM_FABRIC_PORT_EN
  localparam bit FAB_EN = 1'b1;
`else
  localparam bit FAB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  flexbex_dmem_arbiter_if core_if ();
  flexbex_dmem_arbiter_if fab_if ();

  logic [NB-1:0]    bank_csb, bank_web;
  logic [4*NB-1:0]  bank_wmask;
  logic [AW*NB-1:0] bank_addr;
  logic [32*NB-1:0] bank_din, bank_dout;

  flexbex_dmem_arbiter #(
    .NUM_BANKS (NB),
    .BANK_AW   (AW),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core         (core_if),
    .fab          (fab_if),
    .bank_csb_o   (bank_csb),
    .bank_web_o   (bank_web),
    .bank_wmask_o (bank_wmask),
    .bank_addr_o  (bank_addr),
    .bank_din_o   (bank_din),
    .bank_dout_i  (bank_dout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // SRAM bank emulators (port 0: read data appears the cycle after selection)
  logic [31:0] emu_mem  [NB][256];
  logic [31:0] emu_dout [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!bank_csb[b]) begin
        if (!bank_web[b]) begin
          for (int k = 0; k < 4; k++) begin
            if (bank_wmask[b*4+k]) emu_mem[b][bank_addr[b*AW +: AW]][k*8 +: 8] <= bank_din[b*32+k*8 +: 8];
          end
        end else begin
          emu_dout[b] <= emu_mem[b][bank_addr[b*AW +: AW]];
        end
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_dout
    assign bank_dout[g*32 +: 32] = emu_dout[g];
  end

  // Reference model state
  logic [31:0] m_mem [NB*256];
  bit          m_last_fab [NB];
  bit          pc_v, pc_e, pf_v, pf_e;
  logic [31:0] pc_d, pf_d;
  bit          m_gc, m_gf;

  always @(negedge clk) begin : compare
    bit          gc, gf, c_oow, f_oow;
    int          cb, cw, fb, fw;
    logic [NB-1:0]    e_csb, e_web;
    logic [4*NB-1:0]  e_wm;
    logic [AW*NB-1:0] e_addr;
    logic [32*NB-1:0] e_din;
    if (reset) begin
      chk("rst_core_gnt", core_if.gnt, 64'd0);
      chk("rst_fab_gnt", fab_if.gnt, 64'd0);
      chk("rst_core_rvalid", core_if.rvalid, 64'd0);
      chk("rst_fab_rvalid", fab_if.rvalid, 64'd0);
      chk("rst_core_rdata", core_if.rdata, 64'd0);
      chk("rst_csb", bank_csb, 64'(2'b11));
      chk("rst_web", bank_web, 64'(2'b11));
      chk("rst_din", bank_din, 64'd0);
      pc_v = 1'b0; pc_e = 1'b0; pc_d = 32'd0;
      pf_v = 1'b0; pf_e = 1'b0; pf_d = 32'd0;
      for (int b = 0; b < NB; b++) m_last_fab[b] = 1'b1;
      m_gc = 1'b0; m_gf = 1'b0;
    end else begin
      chk("core_rvalid", core_if.rvalid, 64'(pc_v));
      chk("core_err", core_if.err, 64'(pc_v & pc_e));
      chk("core_rdata", core_if.rdata, 64'(pc_v ? pc_d : 32'd0));
      chk("fab_rvalid", fab_if.rvalid, 64'(pf_v));
      chk("fab_err", fab_if.err, 64'(pf_v & pf_e));
      chk("fab_rdata", fab_if.rdata, 64'(pf_v ? pf_d : 32'd0));

      c_oow = core_if.addr >= WIN;
      cb    = int'(core_if.addr / 32'd1024);
      cw    = int'((core_if.addr % 32'd1024) / 32'd4);
      f_oow = fab_if.addr >= WIN;
      fb    = int'(fab_if.addr / 32'd1024);
      fw    = int'((fab_if.addr % 32'd1024) / 32'd4);
      gc = core_if.req;
      gf = FAB_EN && fab_if.req;
      if (gc && gf && !c_oow && !f_oow && cb == fb) begin
        if (m_last_fab[cb]) begin gf = 1'b0; m_last_fab[cb] = 1'b0; end
        else begin gc = 1'b0; m_last_fab[cb] = 1'b1; end
      end
      chk("core_gnt", core_if.gnt, 64'(gc));
      chk("fab_gnt", fab_if.gnt, 64'(gf));

      e_csb = '1; e_web = '1; e_wm = '0; e_addr = '0; e_din = '0;
      for (int b = 0; b < NB; b++) begin
        if (gc && !c_oow && cb == b) begin
          e_csb[b] = 1'b0; e_web[b] = ~core_if.we; e_wm[b*4 +: 4] = core_if.be;
          e_addr[b*AW +: AW] = AW'(cw); e_din[b*32 +: 32] = core_if.wdata;
        end else if (gf && !f_oow && fb == b) begin
          e_csb[b] = 1'b0; e_web[b] = ~fab_if.we; e_wm[b*4 +: 4] = fab_if.be;
          e_addr[b*AW +: AW] = AW'(fw); e_din[b*32 +: 32] = fab_if.wdata;
        end
      end
      chk("bank_csb", bank_csb, 64'(e_csb));
      chk("bank_web", bank_web, 64'(e_web));
      chk("bank_wmask", bank_wmask, 64'(e_wm));
      chk("bank_addr", bank_addr, 64'(e_addr));
      chk("bank_din", bank_din, 64'(e_din));

      pc_v = gc; pc_e = c_oow;
      pc_d = (gc && !c_oow && !core_if.we) ? m_mem[cb*256+cw] : 32'd0;
      pf_v = gf; pf_e = f_oow;
      pf_d = (gf && !f_oow && !fab_if.we) ? m_mem[fb*256+fw] : 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (gc && !c_oow && core_if.we && core_if.be[k]) m_mem[cb*256+cw][k*8 +: 8] = core_if.wdata[k*8 +: 8];
        if (gf && !f_oow && fab_if.we && fab_if.be[k]) m_mem[fb*256+fw][k*8 +: 8] = fab_if.wdata[k*8 +: 8];
      end
      m_gc = gc; m_gf = gf;
    end
  end

  task automatic drive_core(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    core_if.req = req; core_if.we = we; core_if.be = 4'hF; core_if.addr = addr; core_if.wdata = wd;
  endtask

  task automatic drive_fab(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    fab_if.req = req; fab_if.we = we; fab_if.be = 4'hF; fab_if.addr = addr; fab_if.wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = WIN + 32'($urandom_range(0, 1023));
      1:       a = $urandom() | 32'h8000_0000;
      default: a = 32'($urandom_range(0, NB-1)) * 32'd1024
                 + 32'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 255)) * 32'd4
                 + 32'($urandom_range(0, 3));
    endcase
    return a;
  endfunction

  initial begin
    for (int b = 0; b < NB; b++) begin
      emu_dout[b] = 32'd0;
      for (int w = 0; w < 256; w++) begin
        emu_mem[b][w] = 32'd0;
        m_mem[b*256+w] = 32'd0;
      end
    end
    drive_core(1'b1, 1'b0, 32'h4, 32'd0);
    drive_fab(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_rst_gnt", core_if.gnt, 64'd0);
    chk("lit_rst_csb", bank_csb, 64'(2'b11));
    tick(); tick();

    // Core write then read of 0x004
    reset = 1'b0;
    drive_core(1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
    @(negedge clk);
    chk("lit_wr_gnt", core_if.gnt, 64'd1);
    chk("lit_wr_csb", bank_csb, 64'(2'b10));
    chk("lit_wr_web0", bank_web[0], 64'd0);
    chk("lit_wr_addr0", bank_addr[AW-1:0], 64'd1);
    tick(); drive_core(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_wr_rvalid", core_if.rvalid, 64'd1);
    chk("lit_wr_rdata", core_if.rdata, 64'd0);
    tick(); drive_core(1'b1, 1'b0, 32'h4, 32'd0);
    @(negedge clk);
    chk("lit_rd_gnt", core_if.gnt, 64'd1);
    tick(); drive_core(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_rd_rvalid", core_if.rvalid, 64'd1);
    chk("lit_rd_rdata", core_if.rdata, 64'hDEADBEEF);
    chk("lit_rd_err", core_if.err, 64'd0);

    // Out-of-window access
    tick(); drive_core(1'b1, 1'b0, 32'h800, 32'd0);
    @(negedge clk);
    chk("lit_oow_gnt", core_if.gnt, 64'd1);
    chk("lit_oow_csb", bank_csb, 64'(2'b11));
    tick(); drive_core(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_oow_rvalid", core_if.rvalid, 64'd1);
    chk("lit_oow_err", core_if.err, 64'd1);
    chk("lit_oow_rdata", core_if.rdata, 64'd0);

    // Parallel accesses to different banks (fabric ignored when the port is disabled)
    tick(); drive_core(1'b1, 1'b1, 32'h400, 32'hCAFEF00D);
    tick(); drive_core(1'b1, 1'b0, 32'h400, 32'd0); drive_fab(1'b1, 1'b0, 32'h4, 32'd0);
    @(negedge clk);
    chk("lit_par_core_gnt", core_if.gnt, 64'd1);
`ifdef FLEXBEX_DMEM_FABRIC_PORT_EN
    chk("lit_par_fab_gnt", fab_if.gnt, 64'd1);
    chk("lit_par_csb", bank_csb, 64'(2'b00));
`else
    chk("lit_dis_fab_gnt", fab_if.gnt, 64'd0);
    chk("lit_dis_csb", bank_csb, 64'(2'b01));
`endif
    tick(); drive_core(1'b0, 1'b0, 32'h0, 32'd0); drive_fab(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_par_core_rdata", core_if.rdata, 64'hCAFEF00D);
`ifdef FLEXBEX_DMEM_FABRIC_PORT_EN
    chk("lit_par_fab_rdata", fab_if.rdata, 64'hDEADBEEF);

    // Contest on bank 0: core, fabric, core, fabric, then core alone
    tick(); drive_core(1'b1, 1'b0, 32'h000, 32'd0); drive_fab(1'b1, 1'b0, 32'h008, 32'd0);
    @(negedge clk);
    chk("lit_c1_core", core_if.gnt, 64'd1); chk("lit_c1_fab", fab_if.gnt, 64'd0);
    tick(); drive_core(1'b1, 1'b0, 32'h00C, 32'd0);
    @(negedge clk);
    chk("lit_c2_core", core_if.gnt, 64'd0); chk("lit_c2_fab", fab_if.gnt, 64'd1);
    tick(); drive_fab(1'b1, 1'b0, 32'h010, 32'd0);
    @(negedge clk);
    chk("lit_c3_core", core_if.gnt, 64'd1); chk("lit_c3_fab", fab_if.gnt, 64'd0);
    tick(); drive_core(1'b1, 1'b0, 32'h014, 32'd0);
    @(negedge clk);
    chk("lit_c4_core", core_if.gnt, 64'd0); chk("lit_c4_fab", fab_if.gnt, 64'd1);
    tick(); drive_fab(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_c5_core", core_if.gnt, 64'd1);
`else
    chk("lit_dis_fab_rvalid", fab_if.rvalid, 64'd0);
`endif

    // Reset the cycle after a grant
    tick(); drive_core(1'b1, 1'b0, 32'h4, 32'd0); drive_fab(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_pre_rst_gnt", core_if.gnt, 64'd1);
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("lit_midrst_rvalid", core_if.rvalid, 64'd0);
    chk("lit_midrst_gnt", core_if.gnt, 64'd0);
    tick(); reset = 1'b0; drive_core(1'b0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    chk("lit_postrst_rvalid", core_if.rvalid, 64'd0);
    tick(); drive_core(1'b1, 1'b0, 32'h400, 32'd0); drive_fab(1'b1, 1'b0, 32'h404, 32'd0);
    @(negedge clk);
    chk("lit_postrst_core_gnt", core_if.gnt, 64'd1);
    chk("lit_postrst_fab_gnt", fab_if.gnt, 64'd0);

    // Randomized traffic; a refused request is held stable until granted
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 249) == 0);
      if (!(core_if.req && !m_gc)) begin
        drive_core($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
        core_if.be = 4'($urandom_range(0, 15));
      end
      if (!(FAB_EN && fab_if.req && !m_gf)) begin
        drive_fab($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
        fab_if.be = 4'($urandom_range(0, 15));
      end
    end
    tick(); reset = 1'b0;
    drive_core(1'b0, 1'b0, 32'h0, 32'd0); drive_fab(1'b0, 1'b0, 32'h0, 32'd0);
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/flexbex_dmem_arbiter.md
# flexbex_dmem_arbiter

Parametrised data-memory subsystem between the ibex data port, an optional eFPGA-fabric master port, and `NUM_BANKS` banks of `sky130_sram_1kbyte_1rw1r_32x256_8` (port 0 only). It replaces the direct core-to-single-SRAM hookup that held `data_rvalid` constantly high. It produces a true OBI-style gnt/rvalid handshake, decodes a contiguous address window across banks, arbitrates per bank between the two masters, and returns a bus error for out-of-window accesses.

## Interface
- `NUM_BANKS`, 2: SRAM banks, 1..8.
- `BANK_AW`, 8: word-address bits per bank; bank size is 4·2^BANK_AW bytes.
- `BASE_ADDR`, 32'h0000_0000: window base, aligned to the total window size.

- `clk` in 1: single clock for the block and all banks.
- `reset` in 1: asynchronous, active-high reset.
- `core_req_i`, `core_we_i` in 1 each; `core_be_i` in 4; `core_addr_i` in 32; `core_wdata_i` in 32: ibex data request.
- `core_gnt_o`, `core_rvalid_o`, `core_err_o` out 1 each; `core_rdata_o` out 32: ibex response.
- `fab_req_i`, `fab_we_i`, `fab_be_i`, `fab_addr_i`, `fab_wdata_i` in (same widths as core): fabric request, driven via UIO.
- `fab_gnt_o`, `fab_rvalid_o`, `fab_err_o`, `fab_rdata_o` out: fabric response.
- `bank_csb_o` out NUM_BANKS: chip select per bank, active low.
- `bank_web_o` out NUM_BANKS: write enable per bank, active low.
- `bank_wmask_o` out 4·NUM_BANKS: write mask per bank.
- `bank_addr_o` out BANK_AW·NUM_BANKS: word address per bank.
- `bank_din_o` out 32·NUM_BANKS: write data per bank.
- `bank_dout_i` in 32·NUM_BANKS: bank read data, valid the cycle after selection.

## Operation
- Decode: `off = addr − BASE_ADDR`; `bank = off >> (BANK_AW+2)`; `word = off[BANK_AW+1:2]`. The access is out of window if `addr < BASE_ADDR` or `bank ≥ NUM_BANKS`.
- In-window request: the master targets bank `bank`.
  - Uncontested: `gnt` is combinational in the same cycle. Bank `csb=0`, `web=~we`, `wmask=be`, `addr=word`, `din=wdata`.
  - Both masters on the same bank: the winner is the master that did not win the previous contest on that bank. Each bank keeps a 1-bit last-winner register, reset to "fabric" so the core wins the first contest. The loser gets `gnt=0` and must hold its request stable.
  - Different banks: both masters are granted in the same cycle.
- Out-of-window request: `gnt=1` in the same cycle and no bank is selected. Next cycle: `rvalid=1`, `err=1`, `rdata=0`.
- Response:
  - Each master has a pending register {valid, err, bank index} loaded on gnt.
  - Next cycle: `rvalid=1`; `rdata = bank_dout_i[idx]` for reads, 0 for writes and errors.
  - Writes also produce `rvalid`.
  - A new request may be granted in the same cycle as the previous `rvalid` (back-to-back, one access per cycle per master).
- Unselected banks: `csb=1`, `web=1`, other bank outputs 0.

## Timing
- Grant latency is 0 cycles. Response latency is exactly 1 cycle after gnt.
- Reset values: `*_gnt_o=0`, `*_rvalid_o=0`, `*_err_o=0`, `*_rdata_o=0`, `bank_csb_o` all 1, `bank_web_o` all 1, other bank outputs 0. Last-winner registers are set to "fabric".
- While `reset` is high, grants are forced to 0 and `csb` is forced to 1.
- Reset asserted mid-operation clears pending responses; no `rvalid` is issued for an access granted in the cycle reset rises.
- Pending rdata is taken combinationally from the bank. The SRAM output must stay stable for that cycle, which holds because port 0 is not re-selected for another master's read in the response cycle unless that master was granted.

## Configuration
- `FLEXBEX_DMEM_FABRIC_PORT_EN`
  - Defined: the fabric port is active and per-bank arbitration is as above.
  - Undefined: `fab_*_i` are ignored, `fab_gnt_o`, `fab_rvalid_o`, `fab_err_o` and `fab_rdata_o` are tied to 0, last-winner registers are not instantiated, and the core always wins.

## Structure
- Shared package `flexbex_dmem_pkg`:
  - master index enum `{CORE, FAB}`;
  - pending-response struct {valid, err, is_read, bank idx};
  - `WORD_BYTES = 4` constant.
- One sub-module, `flexbex_dmem_decode`: combinational address-to-{bank, word, out_of_window} decode, instantiated once per master.
- Banks are instantiated outside this block, in the SoC top.

## Test plan
- Core write 32'hDEADBEEF to 0x004, then read 0x004 → write gnt cycle 0 with `bank_csb_o[0]=0`, `web=0`, addr=1; rvalid cycle 1; read rvalid cycle 3 with `rdata=32'hDEADBEEF`, `err=0`.
- Core reads 0x400 (bank 1), fabric reads 0x000 (bank 0) in the same cycle → both granted, both rvalid next cycle with the correct bank data.
- Both masters request bank 0 for 3 consecutive cycles → grant order core, fabric, core, fabric, …; the loser's gnt stays 0 until it wins.
- Core reads 0x800 with NUM_BANKS=2 → gnt same cycle, no csb low, next cycle `rvalid=1`, `err=1`, `rdata=0`.
- Assert `reset` the cycle after a gnt → no rvalid; after release all outputs are at reset values and the first contest goes to the core.
- Build without `FLEXBEX_DMEM_FABRIC_PORT_EN`, drive `fab_req_i=1` → `fab_gnt_o` stays 0 and core accesses are unaffected.
